// File: rtl/alarm_unit_if.sv
// rtl/alarm_unit_if.sv - time/button inputs and alarm outputs of the alarm stage
interface alarm_unit_if;
  logic        tick;
  logic [21:0] time_count;
  logic        set_mode;
  logic        en_Time;
  logic        inc;
  logic        dec;
  logic        arm;
  logic        stop;
  logic        snooze;
  logic [21:0] alarm_count;
  logic        alarm_out;
  logic        alarm_led;

  modport master (
    output tick, time_count, set_mode, en_Time, inc, dec, arm, stop, snooze,
    input  alarm_count, alarm_out, alarm_led
  );

  modport slave (
    input  tick, time_count, set_mode, en_Time, inc, dec, arm, stop, snooze,
    output alarm_count, alarm_out, alarm_led
  );
endinterface

// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - BCD alarm register, minute-match detect and ring/snooze/stop FSM
module alarm_unit #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic         clk,
  input  logic         reset,
  alarm_unit_if.slave  bus
);
  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW       = $clog2(MAX_SECS + 1);
  localparam logic [CW-1:0] RING_LD = CW'(RING_SECS);
  localparam logic [CW-1:0] SNZ_LD  = CW'(SNOOZE_SECS);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  state_t        r_state, w_state_nx;
  logic [5:0]    r_hr;
  logic [7:0]    r_min;
  logic          r_match, r_match_d;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_phase, w_phase_nx;
  logic          r_out, r_led;
  logic          w_match, w_fire, w_edit, w_expire;

  function automatic logic [5:0] hr_inc(input logic [5:0] h);
    if (h == 6'h23)        return 6'h00;
    else if (h[3:0] == 4'd9) return {h[5:4] + 2'd1, 4'd0};
    else                   return {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] hr_dec(input logic [5:0] h);
    if (h == 6'h00)        return 6'h23;
    else if (h[3:0] == 4'd0) return {h[5:4] - 2'd1, 4'd9};
    else                   return {h[5:4], h[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m == 8'h59)        return 8'h00;
    else if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    else                   return {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] min_dec(input logic [7:0] m);
    if (m == 8'h00)        return 8'h59;
    else if (m[3:0] == 4'd0) return {m[7:4] - 4'd1, 4'd9};
    else                   return {m[7:4], m[3:0] - 4'd1};
  endfunction

  assign w_match  = (bus.time_count[21:8] == {r_hr, r_min}) && (bus.time_count[7:0] == 8'h00);
  assign w_fire   = r_match & ~r_match_d;
  assign w_edit   = bus.set_mode & (bus.inc ^ bus.dec);
  assign w_expire = bus.tick && (r_cnt <= CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hr      <= 6'h00;
      r_min     <= 8'h00;
      r_match   <= 1'b0;
      r_match_d <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_match_d <= r_match;
      if (w_edit) begin
        if (bus.en_Time) r_hr  <= bus.inc ? hr_inc(r_hr)   : hr_dec(r_hr);
        else             r_min <= bus.inc ? min_inc(r_min) : min_dec(r_min);
      end
    end
  end

  // Every ring burst, including a re-ring after snooze, starts with the LED dark.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_phase_nx = r_phase;
    if (!bus.arm || bus.set_mode) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: if (w_fire) begin
          w_state_nx = RINGING;
          w_cnt_nx   = RING_LD;
          w_phase_nx = 1'b0;
        end
        RINGING: begin
          if (bus.stop) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else if (bus.snooze) begin
            w_state_nx = SNOOZE;
            w_cnt_nx   = SNZ_LD;
          end else if (bus.tick) begin
            w_phase_nx = ~r_phase;
            w_cnt_nx   = w_expire ? '0 : r_cnt - CW'(1);
            if (w_expire) w_state_nx = IDLE;
          end
        end
        SNOOZE: begin
          if (bus.stop) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else if (w_expire) begin
            w_state_nx = RINGING;
            w_cnt_nx   = RING_LD;
            w_phase_nx = 1'b0;
          end else if (bus.tick) begin
            w_cnt_nx   = r_cnt - CW'(1);
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_out   <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_phase <= w_phase_nx;
      r_out   <= (w_state_nx == RINGING);
      r_led   <= (w_state_nx == RINGING) ? w_phase_nx : (w_state_nx == SNOOZE);
    end
  end

  assign bus.alarm_count = {r_hr, r_min, 8'h00};
  assign bus.alarm_out   = r_out;
  assign bus.alarm_led   = r_led;
endmodule

// File: tb/tb_alarm_unit.sv
// tb/tb_alarm_unit.sv - directed and randomized bench for alarm_unit with behavioural model
module tb_alarm_unit;
  localparam int RING   = 4;
  localparam int SNZ    = 3;
  localparam int DAY    = 86400;
  localparam logic [4:0] P_TICK = 5'b10000;
  localparam logic [4:0] P_INC  = 5'b01000;
  localparam logic [4:0] P_DEC  = 5'b00100;
  localparam logic [4:0] P_STOP = 5'b00010;
  localparam logic [4:0] P_SNZ  = 5'b00001;

  logic clk;
  logic reset;
  alarm_unit_if bus();

  alarm_unit #(.RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int tsec    = 0;

  // Model: alarm as integer hour/minute, ring/snooze as flags, seconds left and blink count.
  int m_hr, m_min, m_left, m_blink;
  bit m_flag, m_flag_d, m_ring, m_snz;

  function automatic logic [21:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return 22'((h / 10) << 20 | (h % 10) << 16 | (m / 10) << 12 | (m % 10) << 8 |
               (x / 10) << 4 | (x % 10));
  endfunction

  function automatic logic [21:0] exp_count();
    return to_bcd(m_hr * 3600 + m_min * 60);
  endfunction

  task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hr = 0; m_min = 0; m_left = 0; m_blink = 0;
      m_flag = 0; m_flag_d = 0; m_ring = 0; m_snz = 0;
    end else begin
      bit now_match, fire;
      now_match = (tsec / 3600 == m_hr) && ((tsec / 60) % 60 == m_min) && (tsec % 60 == 0);
      fire      = m_flag && !m_flag_d;
      m_flag_d  = m_flag;
      m_flag    = now_match;
      if (!bus.arm || bus.set_mode) begin
        m_ring = 0; m_snz = 0;
      end else if (m_ring) begin
        if (bus.stop) m_ring = 0;
        else if (bus.snooze) begin m_ring = 0; m_snz = 1; m_left = SNZ; end
        else if (bus.tick) begin
          m_left--; m_blink++;
          if (m_left == 0) m_ring = 0;
        end
      end else if (m_snz) begin
        if (bus.stop) m_snz = 0;
        else if (bus.tick) begin
          m_left--;
          if (m_left == 0) begin m_snz = 0; m_ring = 1; m_left = RING; m_blink = 0; end
        end
      end else if (fire) begin
        m_ring = 1; m_left = RING; m_blink = 0;
      end
      if (bus.set_mode && (bus.inc != bus.dec)) begin
        if (bus.en_Time) m_hr  = bus.inc ? (m_hr + 1) % 24  : (m_hr + 23) % 24;
        else             m_min = bus.inc ? (m_min + 1) % 60 : (m_min + 59) % 60;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_count", bus.alarm_count, exp_count());
      chk("model_out", 22'(bus.alarm_out), 22'(m_ring));
      chk("model_led", 22'(bus.alarm_led), 22'(m_ring ? (m_blink % 2 == 1) : m_snz));
    end
  end

  task automatic set_time(input int s);
    tsec = ((s % DAY) + DAY) % DAY;
    bus.time_count = to_bcd(tsec);
  endtask

  task automatic cyc(input logic [4:0] p);
    bus.tick = p[4]; bus.inc = p[3]; bus.dec = p[2]; bus.stop = p[1]; bus.snooze = p[0];
    if (p[4]) set_time(tsec + 1);
    @(negedge clk);
    bus.tick = 0; bus.inc = 0; bus.dec = 0; bus.stop = 0; bus.snooze = 0;
  endtask

  task automatic fire_0730();
    set_time(7 * 3600 + 29 * 60 + 59);
    repeat (2) cyc(5'b0);
    cyc(P_TICK);
    cyc(5'b0);
  endtask

  task automatic set_alarm(input int h, input int m);
    bus.set_mode = 1; bus.en_Time = 1;
    for (int k = 0; k < 24 && m_hr != h; k++) cyc(P_INC);
    bus.en_Time = 0;
    for (int k = 0; k < 60 && m_min != m; k++) cyc(P_INC);
    bus.set_mode = 0;
  endtask

  initial begin
    reset = 1;
    bus.tick = 0; bus.inc = 0; bus.dec = 0; bus.stop = 0; bus.snooze = 0;
    bus.set_mode = 0; bus.en_Time = 0; bus.arm = 0;
    set_time(0);
    repeat (2) @(negedge clk);
    chk("rst_count", bus.alarm_count, 22'h0);
    chk("rst_out", 22'(bus.alarm_out), 22'h0);
    chk("rst_led", 22'(bus.alarm_led), 22'h0);
    reset = 0;
    set_time(12 * 3600);

    bus.set_mode = 1; bus.en_Time = 0;
    repeat (59) cyc(P_INC);
    chk("min_59", bus.alarm_count, 22'h005900);
    cyc(P_INC);
    chk("min_wrap", bus.alarm_count, 22'h0);
    bus.en_Time = 1;
    cyc(P_DEC);
    chk("hr_wrap", bus.alarm_count, 22'h230000);
    cyc(P_INC | P_DEC);
    chk("inc_dec_same", bus.alarm_count, 22'h230000);
    bus.set_mode = 0;
    cyc(P_INC);
    chk("inc_no_set", bus.alarm_count, 22'h230000);
    bus.set_mode = 1;
    repeat (8) cyc(P_INC);
    bus.en_Time = 0;
    repeat (30) cyc(P_INC);
    bus.set_mode = 0;
    chk("set_0730", bus.alarm_count, 22'h073000);

    bus.arm = 1;
    set_time(7 * 3600 + 29 * 60 + 59);
    repeat (2) cyc(5'b0);
    cyc(P_TICK);
    chk("fire_lat1", 22'(bus.alarm_out), 22'h0);
    cyc(5'b0);
    chk("fire_lat2", 22'(bus.alarm_out), 22'h1);
    cyc(P_STOP);
    chk("stop_out", 22'(bus.alarm_out), 22'h0);
    repeat (20) cyc(5'b0);
    chk("no_refire", 22'(bus.alarm_out), 22'h0);

    fire_0730();
    chk("ring_led0", 22'(bus.alarm_led), 22'h0);
    cyc(P_TICK); chk("ring_t1_out", 22'(bus.alarm_out), 22'h1); chk("ring_t1_led", 22'(bus.alarm_led), 22'h1);
    cyc(P_TICK); chk("ring_t2_led", 22'(bus.alarm_led), 22'h0);
    cyc(P_TICK); chk("ring_t3_out", 22'(bus.alarm_out), 22'h1); chk("ring_t3_led", 22'(bus.alarm_led), 22'h1);
    cyc(P_TICK); chk("ring_auto_out", 22'(bus.alarm_out), 22'h0); chk("ring_auto_led", 22'(bus.alarm_led), 22'h0);

    fire_0730();
    cyc(P_SNZ);
    chk("snz_out", 22'(bus.alarm_out), 22'h0);
    chk("snz_led", 22'(bus.alarm_led), 22'h1);
    cyc(P_TICK); cyc(P_TICK);
    chk("snz_t2_out", 22'(bus.alarm_out), 22'h0);
    cyc(P_TICK);
    chk("snz_rering", 22'(bus.alarm_out), 22'h1);
    cyc(P_STOP);
    chk("snz_stop_out", 22'(bus.alarm_out), 22'h0);
    chk("snz_stop_led", 22'(bus.alarm_led), 22'h0);

    fire_0730();
    cyc(P_STOP | P_SNZ);
    chk("stop_wins_out", 22'(bus.alarm_out), 22'h0);
    chk("stop_wins_led", 22'(bus.alarm_led), 22'h0);
    fire_0730();
    cyc(P_SNZ);
    bus.arm = 0;
    cyc(5'b0);
    chk("disarm_led", 22'(bus.alarm_led), 22'h0);
    bus.arm = 1;

    fire_0730();
    #2 reset = 1;
    #1;
    chk("async_out", 22'(bus.alarm_out), 22'h0);
    chk("async_led", 22'(bus.alarm_led), 22'h0);
    chk("async_count", bus.alarm_count, 22'h0);
    set_time(0);
    @(negedge clk);
    reset = 0;
    cyc(5'b0);
    chk("post_rst_lat1", 22'(bus.alarm_out), 22'h0);
    cyc(5'b0);
    chk("post_rst_fire", 22'(bus.alarm_out), 22'h1);
    cyc(P_STOP);
    repeat (10) cyc(5'b0);
    chk("post_rst_once", 22'(bus.alarm_out), 22'h0);

    set_alarm(12, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] p;
      bus.arm      = ($urandom_range(0, 19) != 0);
      bus.set_mode = ($urandom_range(0, 39) == 0);
      bus.en_Time  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0)
        set_time(m_hr * 3600 + m_min * 60 - int'($urandom_range(0, 3)));
      p[4] = ($urandom_range(0, 2) == 0);
      p[3] = ($urandom_range(0, 3) == 0);
      p[2] = ($urandom_range(0, 3) == 0);
      p[1] = ($urandom_range(0, 29) == 0);
      p[0] = ($urandom_range(0, 14) == 0);
      cyc(p);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage sitting directly downstream of the clock-state block: it consumes the running BCD time word (HH:MM:SS, 22 bits), holds a user-adjustable alarm time, and drives the buzzer and LED outputs. It owns the ring / snooze / stop state machine and exposes the alarm time in the same 22-bit BCD layout, so the existing seven-segment display path can show it in alarm-set mode.

## Interface
Parameters:
- RING_SECS, 60, ticks spent in RINGING before auto-stop (≥1)
- SNOOZE_SECS, 300, ticks spent in SNOOZE before re-ringing (≥1)

Ports:
- clk  in  1  system clock; one clock, all state on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- tick  in  1  one-cycle strobe, once per second, same cycle the time word advances
- time_count  in  22  current time, BCD: [21:20] hr tens, [19:16] hr units, [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units
- set_mode  in  1  1 = alarm time is being edited
- en_Time  in  1  field select while editing: 1 = Hr, 0 = Min
- inc  in  1  one-cycle pulse, increment selected field
- dec  in  1  one-cycle pulse, decrement selected field
- arm  in  1  level; 1 = alarm armed
- stop  in  1  one-cycle pulse, silence alarm
- snooze  in  1  one-cycle pulse, snooze alarm
- alarm_count  out  22  alarm time, same layout as time_count; [7:0] always 0
- alarm_out  out  1  buzzer drive, 1 while in RINGING
- alarm_led  out  1  blinks at 0.5 Hz in RINGING, steady 1 in SNOOZE, 0 in IDLE

## Operation
- Alarm register: BCD hours (00–23), minutes (00–59). Reset value 00:00.
- Editing (set_mode=1 only): inc/dec adjust the field chosen by en_Time. Minutes wrap 59→00 and 00→59 with no carry into hours; hours wrap 23→00 and 00→23. inc and dec in the same cycle: no change. inc/dec ignored when set_mode=0.
- Match: time_count[21:8] == alarm HH:MM and time_count[7:0] == 8'h00. Registered match flag; fire on its rising edge only (one fire per minute entry, none while match stays high).
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE → RINGING: fire, with arm=1 and set_mode=0. Load tick counter with RING_SECS, clear blink phase.
  - RINGING → IDLE: stop, or counter reaches 0 (RING_SECS ticks).
  - RINGING → SNOOZE: snooze (without stop). Load counter with SNOOZE_SECS.
  - SNOOZE → RINGING: counter reaches 0. Reload RING_SECS.
  - SNOOZE → IDLE: stop.
  - Any state → IDLE: arm=0, or set_mode=1.
- Priority, same cycle: reset > (arm=0 or set_mode=1) > stop > snooze > counter expiry > fire.
- Fire while in RINGING or SNOOZE: ignored. Snooze in SNOOZE or IDLE: ignored.
- Counter: decrements on tick only; width ⌈log2(max(RING_SECS,SNOOZE_SECS)+1)⌉. Transition taken on the tick that brings it from 1 to 0.
- Blink phase toggles on every tick in RINGING; alarm_led = phase in RINGING.

## Timing
- Reset (async assert, sync release): state IDLE, alarm 00:00, counter 0, match flag 0, blink phase 0; alarm_count=0, alarm_out=0, alarm_led=0.
- alarm_count updates the cycle after an inc/dec pulse.
- Match flag registered from time_count; alarm_out rises 2 cycles after time_count first shows HH:MM:00 (1 cycle flag, 1 cycle FSM).
- stop/snooze take effect on outputs the cycle after the pulse.
- Auto-stop: alarm_out falls the cycle after the RING_SECS-th tick counted in RINGING.
- Reset mid-ring or mid-snooze: outputs 0 immediately (asynchronous), no re-fire until the next rising match edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then set_mode=1, en_Time=0, 60 inc pulses → alarm_count returns to 22'h0 (minutes wrap, hours unchanged); en_Time=1, one dec → alarm_count[21:16] = 6'h23.
- Alarm 07:30, arm=1, drive time_count 07:29:59→07:30:00 with tick → alarm_out=1 two cycles later; hold 07:30:00 for many cycles → no re-fire after stop.
- RING_SECS=4: fire, issue 4 ticks, no buttons → alarm_out 1 for exactly 4 ticks, alarm_led toggles each tick, then IDLE.
- SNOOZE_SECS=3: fire, snooze → alarm_out=0, alarm_led=1; after 3 ticks alarm_out=1 again; stop → IDLE, both 0.
- stop and snooze in the same cycle while ringing → IDLE (stop wins); arm=0 while in SNOOZE → IDLE next cycle.
- Assert reset mid-RINGING → alarm_out, alarm_led, alarm_count all 0 without a clock edge; match at 00:00:00 with arm=1 after release fires once.
